counter_seq_checker: RTL and testbench

Receive-side monitor for the up/down counter's data_o stream. The block takes the counter output and the same sel_i the counter sees, and predicts each next value. It locks onto the sequence, flags every deviation, and keeps a saturating error count. It sits beside the counter in the synth wrapper, or in a bench, as a synthesizable self-check.

---
 rtl/counter_pkg.sv | 15 +
 rtl/counter_seq_checker_if.sv | 28 ++
 rtl/counter_seq_checker_sat_counter.sv | 26 ++
 rtl/counter_seq_checker.sv | 104 ++++++++++
 tb/tb_counter_seq_checker.sv | 144 ++++++++++++++
 5 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the up/down counter and its sequence checker.
package counter_pkg;

  localparam int CNT_W = 4;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  typedef enum logic [1:0] {
    UNSYNC,
    ACQUIRE,
    LOCKED
  } chk_state_e;

endpackage

// File: rtl/counter_seq_checker_if.sv
// Sample stream into the sequence checker and its status outputs.
interface counter_seq_checker_if
  import counter_pkg::*;
#(
  parameter int WIDTH = CNT_W,
  parameter int ERR_W = 8
) ();

  logic             valid_i;
  logic             sel_i;
  logic [WIDTH-1:0] data_i;
  logic             clr_i;
  logic             locked_o;
  logic             err_o;
  logic [ERR_W-1:0] err_cnt_o;
  logic [WIDTH-1:0] expected_o;

  modport master (
    output valid_i, sel_i, data_i, clr_i,
    input  locked_o, err_o, err_cnt_o, expected_o
  );

  modport slave (
    input  valid_i, sel_i, data_i, clr_i,
    output locked_o, err_o, err_cnt_o, expected_o
  );

endinterface

// File: rtl/counter_seq_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int ERR_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [ERR_W-1:0] cnt_o
);

  logic [ERR_W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != {ERR_W{1'b1}})) begin
      cnt_q <= cnt_q + ERR_W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/counter_seq_checker.sv
// Tracks an up/down counter stream, predicts each next value, and flags and
// counts deviations once the sequence has been locked onto.
module counter_seq_checker
  import counter_pkg::*;
#(
  parameter int WIDTH    = CNT_W,
  parameter int LOCK_CNT = 2,
  parameter int ERR_W    = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  counter_seq_checker_if.slave  bus
);

  localparam int GOOD_W = $clog2(LOCK_CNT + 1);

  chk_state_e       state_q, state_d;
  logic [WIDTH-1:0] expected_q, expected_d;
  logic [GOOD_W-1:0] good_q, good_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic             match;

  function automatic logic [WIDTH-1:0] predict(input logic [WIDTH-1:0] d,
                                               input logic s);
    return (s == DIR_DOWN) ? d - WIDTH'(1) : d + WIDTH'(1);
  endfunction

  assign match = (bus.data_i == expected_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= UNSYNC;
      expected_q <= '0;
      good_q     <= '0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      expected_q <= expected_d;
      good_q     <= good_d;
      locked_q   <= locked_d;
      err_q      <= err_d;
    end
  end

  // Every valid sample re-seeds the prediction, so a mismatch restarts
  // tracking from the offending value rather than the stale expectation.
  always_comb begin
    state_d    = state_q;
    expected_d = expected_q;
    good_d     = good_q;
    locked_d   = locked_q;
    err_d      = 1'b0;
    if (bus.valid_i) begin
      expected_d = predict(bus.data_i, bus.sel_i);
      case (state_q)
        UNSYNC: begin
          good_d  = '0;
          state_d = ACQUIRE;
        end
        ACQUIRE: begin
          if (match) begin
            good_d = good_q + GOOD_W'(1);
            if (good_d == GOOD_W'(LOCK_CNT)) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
            end
          end else begin
            good_d = '0;
          end
        end
        LOCKED: begin
          if (!match) begin
            err_d    = 1'b1;
            locked_d = 1'b0;
            good_d   = '0;
            state_d  = ACQUIRE;
          end
        end
        default: begin
          state_d  = UNSYNC;
          locked_d = 1'b0;
          good_d   = '0;
        end
      endcase
    end
  end

  sat_counter #(
    .ERR_W (ERR_W)
  ) u_err_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (bus.clr_i),
    .inc_i  (err_d),
    .cnt_o  (bus.err_cnt_o)
  );

  assign bus.locked_o   = locked_q;
  assign bus.err_o      = err_q;
  assign bus.expected_o = expected_q;

endmodule

// File: tb/tb_counter_seq_checker.sv
// Directed bench for counter_seq_checker (WIDTH=4, LOCK_CNT=2, ERR_W=2).
module tb_counter_seq_checker;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_fail = 0;
  logic [3:0] e;

  counter_seq_checker_if #(.WIDTH(4), .ERR_W(2)) bus ();

  counter_seq_checker #(
    .WIDTH    (4),
    .LOCK_CNT (2),
    .ERR_W    (2)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic lk, input logic er,
                         input logic [1:0] cnt, input logic [3:0] ex);
    chk({tag, "_locked"},   32'(bus.locked_o),   32'(lk));
    chk({tag, "_err"},      32'(bus.err_o),      32'(er));
    chk({tag, "_errcnt"},   32'(bus.err_cnt_o),  32'(cnt));
    chk({tag, "_expected"}, 32'(bus.expected_o), 32'(ex));
  endtask

  // Apply one cycle of inputs, then look at outputs just after the edge.
  task automatic smp(input logic v, input logic s, input logic [3:0] d, input logic c);
    bus.valid_i = v;
    bus.sel_i   = s;
    bus.data_i  = d;
    bus.clr_i   = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.valid_i = 1'b0;
    bus.sel_i   = 1'b0;
    bus.data_i  = 4'h0;
    bus.clr_i   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_out("reset", 1'b0, 1'b0, 2'd0, 4'h0);
    rst_n = 1'b1;

    // up stream 0,1,2,3: lock after the third sample
    smp(1'b1, 1'b0, 4'h0, 1'b0); chk_out("up0", 1'b0, 1'b0, 2'd0, 4'h1);
    smp(1'b1, 1'b0, 4'h1, 1'b0); chk_out("up1", 1'b0, 1'b0, 2'd0, 4'h2);
    smp(1'b1, 1'b0, 4'h2, 1'b0); chk_out("up2", 1'b1, 1'b0, 2'd0, 4'h3);
    smp(1'b1, 1'b0, 4'h3, 1'b0); chk_out("up3", 1'b1, 1'b0, 2'd0, 4'h4);

    // wrap upward then downward
    for (int d = 4; d <= 13; d++) smp(1'b1, 1'b0, 4'(d), 1'b0);
    chk_out("ramp", 1'b1, 1'b0, 2'd0, 4'hE);
    smp(1'b1, 1'b0, 4'hE, 1'b0); chk_out("upE", 1'b1, 1'b0, 2'd0, 4'hF);
    smp(1'b1, 1'b0, 4'hF, 1'b0); chk_out("wrap_up", 1'b1, 1'b0, 2'd0, 4'h0);
    smp(1'b1, 1'b0, 4'h0, 1'b0); chk_out("up0b", 1'b1, 1'b0, 2'd0, 4'h1);
    smp(1'b1, 1'b0, 4'h1, 1'b0); chk_out("up1b", 1'b1, 1'b0, 2'd0, 4'h2);
    smp(1'b1, 1'b1, 4'h2, 1'b0); chk_out("dn2", 1'b1, 1'b0, 2'd0, 4'h1);
    smp(1'b1, 1'b1, 4'h1, 1'b0); chk_out("dn1", 1'b1, 1'b0, 2'd0, 4'h0);
    smp(1'b1, 1'b1, 4'h0, 1'b0); chk_out("wrap_dn", 1'b1, 1'b0, 2'd0, 4'hF);
    smp(1'b1, 1'b1, 4'hF, 1'b0); chk_out("dnF", 1'b1, 1'b0, 2'd0, 4'hE);
    smp(1'b1, 1'b1, 4'hE, 1'b0); chk_out("dnE", 1'b1, 1'b0, 2'd0, 4'hD);

    // back to counting up, D..4, then a glitch 7 -> 9
    for (int i = 0; i < 8; i++) smp(1'b1, 1'b0, 4'(13 + i), 1'b0);
    chk_out("to5", 1'b1, 1'b0, 2'd0, 4'h5);
    smp(1'b1, 1'b0, 4'h5, 1'b0);
    smp(1'b1, 1'b0, 4'h6, 1'b0);
    smp(1'b1, 1'b0, 4'h7, 1'b0); chk_out("pre_glitch", 1'b1, 1'b0, 2'd0, 4'h8);
    smp(1'b1, 1'b0, 4'h9, 1'b0); chk_out("glitch", 1'b0, 1'b1, 2'd1, 4'hA);
    smp(1'b1, 1'b0, 4'hA, 1'b0); chk_out("post_glitch", 1'b0, 1'b0, 2'd1, 4'hB);
    smp(1'b1, 1'b0, 4'hB, 1'b0); chk_out("relock", 1'b1, 1'b0, 2'd1, 4'hC);

    // repeated glitches: error count saturates at 3
    e = 4'hC;
    for (int k = 1; k <= 5; k++) begin
      smp(1'b1, 1'b0, e + 4'd8, 1'b0);
      chk_out("sat_glitch", 1'b0, 1'b1, (k >= 2) ? 2'd3 : 2'd2, e + 4'd9);
      smp(1'b1, 1'b0, e + 4'd9, 1'b0);
      smp(1'b1, 1'b0, e + 4'd10, 1'b0);
      chk_out("sat_relock", 1'b1, 1'b0, (k >= 2) ? 2'd3 : 2'd2, e + 4'd11);
      e = e + 4'd11;
    end

    // clear coincident with a glitch: clear wins, pulse still fires
    smp(1'b1, 1'b0, e + 4'd8, 1'b1); chk_out("clr_glitch", 1'b0, 1'b1, 2'd0, e + 4'd9);
    smp(1'b1, 1'b0, e + 4'd9, 1'b0);
    smp(1'b1, 1'b0, e + 4'd10, 1'b0); chk_out("clr_relock", 1'b1, 1'b0, 2'd0, e + 4'd11);
    e = e + 4'd11;
    smp(1'b1, 1'b0, e + 4'd5, 1'b0); chk_out("cnt_again", 1'b0, 1'b1, 2'd1, e + 4'd6);
    smp(1'b1, 1'b0, e + 4'd6, 1'b0);
    smp(1'b1, 1'b0, e + 4'd7, 1'b0); chk_out("cnt_relock", 1'b1, 1'b0, 2'd1, e + 4'd8);

    // asynchronous reset between edges while locked
    #3;
    rst_n = 1'b0;
    #1;
    chk_out("async_rst", 1'b0, 1'b0, 2'd0, 4'h0);
    @(posedge clk);
    #1;
    chk_out("rst_hold", 1'b0, 1'b0, 2'd0, 4'h0);
    rst_n = 1'b1;

    // relock from scratch with a valid gap in the middle
    smp(1'b1, 1'b0, 4'h3, 1'b0); chk_out("gap3", 1'b0, 1'b0, 2'd0, 4'h4);
    for (int i = 0; i < 4; i++) begin
      smp(1'b0, 1'b1, 4'h7, 1'b0);
      chk_out("gap_idle", 1'b0, 1'b0, 2'd0, 4'h4);
    end
    smp(1'b1, 1'b0, 4'h4, 1'b0); chk_out("gap4", 1'b0, 1'b0, 2'd0, 4'h5);
    smp(1'b1, 1'b0, 4'h5, 1'b0); chk_out("gap5", 1'b1, 1'b0, 2'd0, 4'h6);

    // mismatch during acquisition: no error, match run restarts
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    smp(1'b1, 1'b0, 4'h3, 1'b0); chk_out("acq3", 1'b0, 1'b0, 2'd0, 4'h4);
    smp(1'b1, 1'b0, 4'h4, 1'b0); chk_out("acq4", 1'b0, 1'b0, 2'd0, 4'h5);
    smp(1'b1, 1'b0, 4'h8, 1'b0); chk_out("acq_miss", 1'b0, 1'b0, 2'd0, 4'h9);
    smp(1'b1, 1'b0, 4'h9, 1'b0); chk_out("acq9", 1'b0, 1'b0, 2'd0, 4'hA);
    smp(1'b1, 1'b0, 4'hA, 1'b0); chk_out("acqA", 1'b1, 1'b0, 2'd0, 4'hB);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
